// File: rtl/ps2_player_keys.sv
// PS/2 keyboard front end for the two-player game.
// Receives device-to-host PS/2 frames and turns make/break scan codes
// (including the E0 extended page and F0 break prefix) into one held-level
// flag per game key for the Fireboy and Icegirl controllers.
module ps2_player_keys #(
  parameter int CLK_HZ         = 50000000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 500
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       fireboy_jump,
  output logic       fireboy_left,
  output logic       fireboy_right,
  output logic       icegirl_jump,
  output logic       icegirl_left,
  output logic       icegirl_right,
  output logic       code_valid,
  output logic [7:0] code_byte,
  output logic       frame_error
);

  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_SHIFT  = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  localparam logic [1:0] D_BASE    = 2'd0;
  localparam logic [1:0] D_EXT     = 2'd1;
  localparam logic [1:0] D_BRK     = 2'd2;
  localparam logic [1:0] D_EXT_BRK = 2'd3;

  // Key flag bit order: {fireboy jump/left/right, icegirl jump/left/right}
  function automatic logic [5:0] keyMask(input logic ext, input logic [7:0] code);
    logic [5:0] m;
    m = '0;
    if (ext) begin
      case (code)
        8'h75:   m = 6'b100000;
        8'h6B:   m = 6'b010000;
        8'h74:   m = 6'b001000;
        default: m = '0;
      endcase
    end else begin
      case (code)
        8'h1D:   m = 6'b000100;
        8'h1C:   m = 6'b000010;
        8'h23:   m = 6'b000001;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  logic        clkMeta_q, clkSync_q, clkPrev_q;
  logic        dataMeta_q, dataSync_q;
  logic        fall;

  logic [1:0]  rxState_q, rxState_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [16:0] toCnt_q, toCnt_d;
  logic [7:0]  codeByte_q, codeByte_d;
  logic        codeValid_q, codeValid_d;
  logic        frameErr_q, frameErr_d;

  logic [1:0]  decState_q, decState_d;
  logic [5:0]  keys_q, keys_d;

  // Two-flop synchronizers plus one history flop for PS/2 clock edge detection
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      clkPrev_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
    end else begin
      clkMeta_q  <= ps2_clk;
      clkSync_q  <= clkMeta_q;
      clkPrev_q  <= clkSync_q;
      dataMeta_q <= ps2_data;
      dataSync_q <= dataMeta_q;
    end
  end

  assign fall = clkPrev_q & ~clkSync_q;

  // Frame receiver: start, 8 data bits LSB first, odd parity, stop, with idle timeout
  always_comb begin
    rxState_d   = rxState_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    toCnt_d     = toCnt_q;
    codeByte_d  = codeByte_q;
    codeValid_d = 1'b0;
    frameErr_d  = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        toCnt_d = '0;
        if (fall) begin
          if (!dataSync_q) begin
            rxState_d = RX_SHIFT;
            bitCnt_d  = '0;
          end else begin
            frameErr_d = 1'b1;
          end
        end
      end
      RX_SHIFT: begin
        if (fall) begin
          shift_d  = {dataSync_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) rxState_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          parity_d  = dataSync_q;
          rxState_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          if (dataSync_q && (^{shift_q, parity_q})) begin
            codeByte_d  = shift_q;
            codeValid_d = 1'b1;
          end else begin
            frameErr_d = 1'b1;
          end
          rxState_d = RX_IDLE;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
    if (rxState_q != RX_IDLE) begin
      if (fall) begin
        toCnt_d = '0;
      end else if (toCnt_q == TIMEOUT_LAST) begin
        rxState_d  = RX_IDLE;
        frameErr_d = 1'b1;
        shift_d    = '0;
        toCnt_d    = '0;
      end else begin
        toCnt_d = toCnt_q + 17'd1;
      end
    end
  end

  // Receiver state and output pulse registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rxState_q   <= RX_IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      toCnt_q     <= '0;
      codeByte_q  <= 8'h00;
      codeValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      rxState_q   <= rxState_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      toCnt_q     <= toCnt_d;
      codeByte_q  <= codeByte_d;
      codeValid_q <= codeValid_d;
      frameErr_q  <= frameErr_d;
    end
  end

  // Scan-code decoder: tracks E0/F0 prefixes and sets or clears key flags
  always_comb begin
    decState_d = decState_q;
    keys_d     = keys_q;
    if (codeValid_q) begin
      case (decState_q)
        D_BASE: begin
          if (codeByte_q == 8'hE0)      decState_d = D_EXT;
          else if (codeByte_q == 8'hF0) decState_d = D_BRK;
          else                          keys_d = keys_q | keyMask(1'b0, codeByte_q);
        end
        D_EXT: begin
          if (codeByte_q == 8'hF0) begin
            decState_d = D_EXT_BRK;
          end else if (codeByte_q != 8'hE0) begin
            keys_d     = keys_q | keyMask(1'b1, codeByte_q);
            decState_d = D_BASE;
          end
        end
        D_BRK: begin
          if (codeByte_q != 8'hE0 && codeByte_q != 8'hF0)
            keys_d = keys_q & ~keyMask(1'b0, codeByte_q);
          decState_d = D_BASE;
        end
        D_EXT_BRK: begin
          if (codeByte_q != 8'hE0 && codeByte_q != 8'hF0)
            keys_d = keys_q & ~keyMask(1'b1, codeByte_q);
          decState_d = D_BASE;
        end
        default: decState_d = D_BASE;
      endcase
    end
  end

  // Decoder state and held key flags
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      decState_q <= D_BASE;
      keys_q     <= '0;
    end else begin
      decState_q <= decState_d;
      keys_q     <= keys_d;
    end
  end

  assign fireboy_jump  = keys_q[5];
  assign fireboy_left  = keys_q[4];
  assign fireboy_right = keys_q[3];
  assign icegirl_jump  = keys_q[2];
  assign icegirl_left  = keys_q[1];
  assign icegirl_right = keys_q[0];
  assign code_valid    = codeValid_q;
  assign code_byte     = codeByte_q;
  assign frame_error   = frameErr_q;

endmodule

// File: tb/tb_ps2_player_keys.sv
// Self-checking bench for ps2_player_keys.
// Drives PS/2 frames with a shortened bit period and a small timeout so the
// whole run stays short, and compares every output on every cycle against a
// scan-code model that works on whole bytes and prefix flags.
module tb_ps2_player_keys;

  localparam int H = 20;
  localparam int T = 200;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       fireboyJump, fireboyLeft, fireboyRight;
  logic       icegirlJump, icegirlLeft, icegirlRight;
  logic       codeValid, frameError;
  logic [7:0] codeByte;
  logic [5:0] dutKeys;

  logic       expValid = 1'b0;
  logic       expErr = 1'b0;
  logic [7:0] expByte = 8'h00;
  logic [5:0] expKeys = 6'b000000;
  bit         extPend = 1'b0;
  bit         brkPend = 1'b0;
  bit         checkEn = 1'b0;

  int cyc = 0;
  int lastFall = 0;
  int assertCount = 0;
  int failCount = 0;

  ps2_player_keys #(.TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ps2_clk(ps2Clk),
    .ps2_data(ps2Data),
    .fireboy_jump(fireboyJump),
    .fireboy_left(fireboyLeft),
    .fireboy_right(fireboyRight),
    .icegirl_jump(icegirlJump),
    .icegirl_left(icegirlLeft),
    .icegirl_right(icegirlRight),
    .code_valid(codeValid),
    .code_byte(codeByte),
    .frame_error(frameError)
  );

  assign dutKeys = {fireboyJump, fireboyLeft, fireboyRight, icegirlJump, icegirlLeft, icegirlRight};

  // Free-running system clock
  always #5 Clk = ~Clk;

  // Cycle counter used to place timeout expectations
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      if (failCount <= 40)
        $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key map of the game: which flag (bit index) a code controls on a page
  function automatic int keyBit(input bit ext, input logic [7:0] code);
    if (ext) begin
      if (code == 8'h75) return 5;
      if (code == 8'h6B) return 4;
      if (code == 8'h74) return 3;
    end else begin
      if (code == 8'h1D) return 2;
      if (code == 8'h1C) return 1;
      if (code == 8'h23) return 0;
    end
    return -1;
  endfunction

  // Scan-code semantics: prefixes accumulate, the next plain byte acts on the key
  task automatic modelDecode(input logic [7:0] b);
    int k;
    if (brkPend) begin
      k = keyBit(extPend, b);
      if (b != 8'hE0 && b != 8'hF0 && k >= 0) expKeys[k] = 1'b0;
      extPend = 1'b0;
      brkPend = 1'b0;
    end else if (b == 8'hE0) begin
      extPend = 1'b1;
    end else if (b == 8'hF0) begin
      brkPend = 1'b1;
    end else begin
      k = keyBit(extPend, b);
      if (k >= 0) expKeys[k] = 1'b1;
      extPend = 1'b0;
    end
  endtask

  // Compare every DUT output against the model on the inactive clock edge
  always @(negedge Clk) begin
    if (checkEn) begin
      checkOutput("code_valid", 32'(codeValid), 32'(expValid));
      checkOutput("frame_error", 32'(frameError), 32'(expErr));
      checkOutput("code_byte", 32'(codeByte), 32'(expByte));
      checkOutput("key_flags", 32'(dutKeys), 32'(expKeys));
    end
  end

  // Send one complete frame; the model learns the byte when the DUT should report it
  task automatic applyStimulus(input logic [7:0] b, input logic parityOk, input logic stopBit);
    logic [10:0] bits;
    logic        good;
    bits = {stopBit, (parityOk ? ~^b : ^b), b, 1'b0};
    good = parityOk & stopBit;
    for (int i = 0; i < 11; i++) begin
      ps2Data = bits[i];
      repeat (H) @(posedge Clk);
      #1;
      ps2Clk = 1'b0;
      if (i == 10) begin
        repeat (3) @(posedge Clk);
        #1;
        if (good) begin
          expValid = 1'b1;
          expByte  = b;
        end else begin
          expErr = 1'b1;
        end
        @(posedge Clk);
        #1;
        expValid = 1'b0;
        expErr   = 1'b0;
        if (good) modelDecode(b);
        repeat (H - 4) @(posedge Clk);
        #1;
      end else begin
        repeat (H) @(posedge Clk);
        #1;
      end
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
    repeat (H) @(posedge Clk);
    #1;
  endtask

  // Send only the first n bits of a frame (start bit first), ending with the clock high
  task automatic sendPartial(input logic [7:0] b, input int n);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2Data = bits[i];
      repeat (H) @(posedge Clk);
      #1;
      ps2Clk = 1'b0;
      lastFall = cyc;
      repeat (H) @(posedge Clk);
      #1;
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
  endtask

  // A lone falling edge with data high is a bad start bit
  task automatic sendBadStart();
    ps2Data = 1'b1;
    repeat (H) @(posedge Clk);
    #1;
    ps2Clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    expErr = 1'b1;
    @(posedge Clk);
    #1;
    expErr = 1'b0;
    repeat (H - 4) @(posedge Clk);
    #1;
    ps2Clk = 1'b1;
    repeat (H) @(posedge Clk);
    #1;
  endtask

  task automatic modelReset();
    expKeys  = '0;
    expByte  = 8'h00;
    expValid = 1'b0;
    expErr   = 1'b0;
    extPend  = 1'b0;
    brkPend  = 1'b0;
  endtask

  // Directed scenario sequence with literal checkpoints
  initial begin
    int remaining;
    #1;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checkEn = 1'b1;
    checkOutput("reset_keys", 32'(dutKeys), 32'h0);
    checkOutput("reset_byte", 32'(codeByte), 32'h0);
    Reset = 1'b0;
    repeat (5) @(posedge Clk);
    #1;

    // Single base-page make
    applyStimulus(8'h1D, 1'b1, 1'b1);
    checkOutput("t1_keys", 32'(dutKeys), 32'h04);
    checkOutput("t1_byte", 32'(codeByte), 32'h1D);
    checkOutput("t1_model", 32'(expKeys), 32'h04);

    // Extended make then extended break
    applyStimulus(8'hE0, 1'b1, 1'b1);
    applyStimulus(8'h6B, 1'b1, 1'b1);
    checkOutput("t2_make", 32'(dutKeys), 32'h14);
    applyStimulus(8'hE0, 1'b1, 1'b1);
    applyStimulus(8'hF0, 1'b1, 1'b1);
    applyStimulus(8'h6B, 1'b1, 1'b1);
    checkOutput("t2_break", 32'(dutKeys), 32'h04);

    // Bad parity, bad stop and bad start are rejected; code_byte is held
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkOutput("t3_parity_keys", 32'(dutKeys), 32'h04);
    checkOutput("t3_parity_byte", 32'(codeByte), 32'h6B);
    applyStimulus(8'h1C, 1'b1, 1'b0);
    sendBadStart();
    applyStimulus(8'h1C, 1'b1, 1'b1);
    checkOutput("t3_good", 32'(dutKeys), 32'h06);

    // Partial frame abandoned by timeout, then a good frame
    sendPartial(8'h23, 4);
    remaining = lastFall + 3 + T - cyc;
    repeat (remaining) @(posedge Clk);
    #1;
    expErr = 1'b1;
    @(posedge Clk);
    #1;
    expErr = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    applyStimulus(8'h23, 1'b1, 1'b1);
    checkOutput("t4_after_timeout", 32'(dutKeys), 32'h07);

    // Typematic repeat, simultaneous flags, release only one
    applyStimulus(8'h23, 1'b1, 1'b1);
    applyStimulus(8'hE0, 1'b1, 1'b1);
    applyStimulus(8'h74, 1'b1, 1'b1);
    checkOutput("t5_both", 32'(dutKeys), 32'h0F);
    applyStimulus(8'hF0, 1'b1, 1'b1);
    applyStimulus(8'h23, 1'b1, 1'b1);
    checkOutput("t5_release", 32'(dutKeys), 32'h0E);

    // Reset in the middle of a frame
    applyStimulus(8'hE0, 1'b1, 1'b1);
    applyStimulus(8'h75, 1'b1, 1'b1);
    checkOutput("t6_before", 32'(dutKeys), 32'h2E);
    sendPartial(8'hE0, 3);
    Reset = 1'b1;
    modelReset();
    #2;
    checkOutput("t6_reset_keys", 32'(dutKeys), 32'h0);
    checkOutput("t6_reset_byte", 32'(codeByte), 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    applyStimulus(8'hE0, 1'b1, 1'b1);
    applyStimulus(8'h75, 1'b1, 1'b1);
    checkOutput("t6_after", 32'(dutKeys), 32'h20);

    // Wrong-page codes, unmapped code and a malformed break sequence
    applyStimulus(8'hE0, 1'b1, 1'b1);
    applyStimulus(8'h1D, 1'b1, 1'b1);
    applyStimulus(8'h75, 1'b1, 1'b1);
    applyStimulus(8'h5A, 1'b1, 1'b1);
    applyStimulus(8'hF0, 1'b1, 1'b1);
    applyStimulus(8'hE0, 1'b1, 1'b1);
    applyStimulus(8'h1C, 1'b1, 1'b1);
    checkOutput("t7_keys", 32'(dutKeys), 32'h22);

    repeat (10) @(posedge Clk);
    #1;
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
